vector_lsu: RTL

//  Parametrised vector load/store engine between the MEM stage and the scalar D-bus.

---
 rtl/vector_lsu_if.sv | 42 ++++
 rtl/vector_lsu.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/vector_lsu_if.sv
// Bundles the request/response handshake and the scalar D-bus of the vector load/store engine.
// slave = the engine's view, master = the requester / bus-model side.
interface vector_lsu_if #(
  parameter int VL     = 8,
  parameter int SEW    = 32,
  parameter int ADDR_W = 32
);
  localparam int VL_W = $clog2(VL + 1);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] req_stride;
  logic [VL_W-1:0]   req_vl;
  logic [VL-1:0]     req_mask;
  logic [VL*SEW-1:0] req_vdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [VL*SEW-1:0] resp_vdata;
  logic              busy;
  logic              D_enable;
  logic              D_write;
  logic [ADDR_W-1:0] D_addr;
  logic [SEW-1:0]    D_wdata;
  logic              D_ready;
  logic [SEW-1:0]    D_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_stride, req_vl, req_mask, req_vdata,
    input  resp_ready, D_ready, D_rdata,
    output req_ready, resp_valid, resp_vdata, busy,
    output D_enable, D_write, D_addr, D_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_stride, req_vl, req_mask, req_vdata,
    output resp_ready, D_ready, D_rdata,
    input  req_ready, resp_valid, resp_vdata, busy,
    input  D_enable, D_write, D_addr, D_wdata
  );
endinterface

// File: rtl/vector_lsu.sv
// Vector load/store engine: walks up to VL strided elements, one D-bus beat per active element,
// and returns the assembled register (mask- and tail-undisturbed) with a completion handshake.
module vector_lsu #(
  parameter int VL     = 8,
  parameter int SEW    = 32,
  parameter int ADDR_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  vector_lsu_if.slave  bus
);
  localparam int VL_W  = $clog2(VL + 1);
  localparam int IDX_W = (VL > 1) ? $clog2(VL) : 1;

  typedef enum logic [1:0] {IDLE, STEP, BEAT, DONE} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] eaddr_q, eaddr_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [VL_W-1:0]   vl_q, vl_d;
  logic [VL-1:0]     mask_q, mask_d;
  logic [SEW-1:0]    elem_q [VL];
  logic [SEW-1:0]    elem_d [VL];
  logic              d_enable_q, d_enable_d;
  logic              d_write_q, d_write_d;
  logic [ADDR_W-1:0] d_addr_q, d_addr_d;
  logic [SEW-1:0]    d_wdata_q, d_wdata_d;

  logic             accept, beat, last, next_on;
  logic [IDX_W-1:0] cnt_inc;

  assign accept  = bus.req_valid && (state_q == IDLE);
  assign beat    = (state_q == BEAT) && d_enable_q && bus.D_ready;
  assign last    = (VL_W'(cnt_q) == vl_q - VL_W'(1));
  assign cnt_inc = cnt_q + IDX_W'(1);
  assign next_on = mask_q[cnt_inc];

  // State register plus datapath flops; reset aborts any transfer immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      write_q    <= 1'b0;
      eaddr_q    <= '0;
      stride_q   <= '0;
      vl_q       <= '0;
      mask_q     <= '0;
      elem_q     <= '{default: '0};
      d_enable_q <= 1'b0;
      d_write_q  <= 1'b0;
      d_addr_q   <= '0;
      d_wdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      write_q    <= write_d;
      eaddr_q    <= eaddr_d;
      stride_q   <= stride_d;
      vl_q       <= vl_d;
      mask_q     <= mask_d;
      elem_q     <= elem_d;
      d_enable_q <= d_enable_d;
      d_write_q  <= d_write_d;
      d_addr_q   <= d_addr_d;
      d_wdata_q  <= d_wdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (bus.req_vl == '0) ? DONE : STEP;
      STEP: begin
        if (mask_q[cnt_q]) state_d = BEAT;
        else if (last)     state_d = DONE;
      end
      BEAT: if (beat) state_d = last ? DONE : (next_on ? BEAT : STEP);
      DONE: if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: eaddr_q tracks base + cnt*stride incrementally, which is identical mod 2^ADDR_W.
  always_comb begin
    cnt_d      = cnt_q;
    write_d    = write_q;
    eaddr_d    = eaddr_q;
    stride_d   = stride_q;
    vl_d       = vl_q;
    mask_d     = mask_q;
    elem_d     = elem_q;
    d_enable_d = d_enable_q;
    d_write_d  = d_write_q;
    d_addr_d   = d_addr_q;
    d_wdata_d  = d_wdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d    = '0;
          write_d  = bus.req_write;
          eaddr_d  = bus.req_addr;
          stride_d = bus.req_stride;
          vl_d     = bus.req_vl;
          mask_d   = bus.req_mask;
          for (int i = 0; i < VL; i++) elem_d[i] = bus.req_vdata[i*SEW +: SEW];
        end
      end
      STEP: begin
        if (mask_q[cnt_q]) begin
          d_enable_d = 1'b1;
          d_write_d  = write_q;
          d_addr_d   = eaddr_q;
          d_wdata_d  = elem_q[cnt_q];
        end else if (!last) begin
          cnt_d   = cnt_inc;
          eaddr_d = eaddr_q + stride_q;
        end
      end
      BEAT: begin
        if (beat) begin
          if (!write_q) elem_d[cnt_q] = bus.D_rdata;
          if (last) begin
            d_enable_d = 1'b0;
          end else begin
            cnt_d   = cnt_inc;
            eaddr_d = eaddr_q + stride_q;
            if (next_on) begin
              d_addr_d  = eaddr_q + stride_q;
              d_wdata_d = elem_q[cnt_inc];
            end else begin
              d_enable_d = 1'b0;
            end
          end
        end
      end
      DONE: if (bus.resp_ready) cnt_d = '0;
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == DONE);
    bus.busy       = (state_q != IDLE);
  end

  assign bus.D_enable = d_enable_q;
  assign bus.D_write  = d_write_q;
  assign bus.D_addr   = d_addr_q;
  assign bus.D_wdata  = d_wdata_q;

  for (genvar gi = 0; gi < VL; gi++) begin : g_pack
    assign bus.resp_vdata[gi*SEW +: SEW] = elem_q[gi];
  end
endmodule
